// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell walked across WIDTH-bit
// operands LSB first, one bit per clock, with start/busy/done handshake.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shift_a, shift_b, res, res_nx;
    logic [CW-1:0]    cnt;
    logic             borrow, borrow_nx, d, last;

    // One full-subtractor cell; the new bit enters res at the MSB so after
    // WIDTH shifts the LSB of the result sits at bit 0.
    always_comb begin
        d         = shift_a[0] ^ shift_b[0] ^ borrow;
        borrow_nx = (~shift_a[0] & shift_b[0]) | (~(shift_a[0] ^ shift_b[0]) & borrow);
        res_nx    = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
        last      = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // busy/done are flopped from the next-state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            res     <= '0;
            diff    <= '0;
            b_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_a <= a;
                        shift_b <= b;
                        borrow  <= b_in;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    borrow  <= borrow_nx;
                    res     <= res_nx;
                    cnt     <= cnt + CW'(1);
                    // Result is published only on the edge that enters DONE.
                    if (last) begin
                        diff  <= res_nx;
                        b_out <= borrow_nx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, bin0, busy0, done0, bout0;
    logic [7:0] a0, b0, diff0;
    logic       rst1, start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;

    serial_sub_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst0), .start(start0), .a(a0), .b(b0), .b_in(bin0),
        .busy(busy0), .done(done0), .diff(diff0), .b_out(bout0)
    );
    serial_sub_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .b_in(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .b_out(bout1)
    );

    typedef struct {
        longint d;
        bit     bo;
        int     edge_at;
    } exp_t;

    exp_t   sbq[2][$];
    int     acc[2] = '{-1, -1};
    longint cur_d[2], held_d[2];
    bit     cur_b[2], held_b[2];
    bit     e_busy[2], e_done[2];
    bit     armed[2] = '{1'b0, 1'b0};
    int     edge_n = 0;
    int     n_chk = 0, n_fail = 0;

    // Reference model: an operation accepted at edge E occupies the unit
    // until edge E+w+1; the result is plain modular arithmetic.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int     w;
            bit     r, s, bi;
            longint av, bv;
            exp_t   e;
            w  = (u == 0) ? 8 : 1;
            r  = (u == 0) ? rst0 : rst1;
            s  = (u == 0) ? start0 : start1;
            av = (u == 0) ? longint'(a0) : longint'(a1);
            bv = (u == 0) ? longint'(b0) : longint'(b1);
            bi = (u == 0) ? bin0 : bin1;
            if (r) begin
                acc[u] = -1;
                sbq[u].delete();
                held_d[u] = 0;
                held_b[u] = 0;
                armed[u] = 1;
            end else if (acc[u] >= 0) begin
                if (edge_n - acc[u] == w) begin
                    held_d[u] = cur_d[u];
                    held_b[u] = cur_b[u];
                end else if (edge_n - acc[u] == w + 1) begin
                    acc[u] = -1;
                end
            end else if (s) begin
                acc[u]   = edge_n;
                cur_d[u] = (av - bv - longint'(bi)) & ((64'd1 << w) - 1);
                cur_b[u] = (av < bv + longint'(bi));
                e.d = cur_d[u];
                e.bo = cur_b[u];
                e.edge_at = edge_n + w;
                sbq[u].push_back(e);
            end
            e_busy[u] = (acc[u] >= 0) && (edge_n - acc[u] < w);
            e_done[u] = (acc[u] >= 0) && (edge_n - acc[u] == w);
        end
        edge_n++;
    end

    task automatic chk(input string nm, input int u, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (w%0d) at edge %0d: got %0h expected %0h", nm, (u == 0) ? 8 : 1, edge_n - 1, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a done pulse is presented.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic        bz, dn, bo;
            logic [63:0] dv;
            exp_t        e;
            if (armed[u]) begin
                bz = (u == 0) ? busy0 : busy1;
                dn = (u == 0) ? done0 : done1;
                bo = (u == 0) ? bout0 : bout1;
                dv = (u == 0) ? {56'b0, diff0} : {63'b0, diff1};
                chk("busy", u, {63'b0, bz}, {63'b0, e_busy[u]});
                chk("done", u, {63'b0, dn}, {63'b0, e_done[u]});
                chk("busy_and_done", u, {63'b0, bz & dn}, 64'd0);
                if (dn === 1'b1) begin
                    if (sbq[u].size() == 0) begin
                        chk("done_without_request", u, 64'd1, 64'd0);
                    end else begin
                        e = sbq[u].pop_front();
                        chk("diff", u, dv, e.d);
                        chk("b_out", u, {63'b0, bo}, {63'b0, e.bo});
                        chk("done_edge", u, 64'(edge_n - 1), 64'(e.edge_at));
                    end
                end else begin
                    chk("diff_hold", u, dv, held_d[u]);
                    chk("b_out_hold", u, {63'b0, bo}, {63'b0, held_b[u]});
                end
            end
        end
    end

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        a0 = av; b0 = bv; bin0 = bi; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); bin0 = 1'($urandom);
        repeat (9) @(negedge clk);
    endtask

    task automatic op1(input logic av, input logic bv, input logic bi);
        a1 = av; b1 = bv; bin1 = bi; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        a1 = ~av; b1 = ~bv; bin1 = ~bi;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; bin0 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (2) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) @(negedge clk);

        op8(8'h35, 8'h12, 1'b0);
        op8(8'h00, 8'h01, 1'b0);
        op8(8'h80, 8'h80, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1);
        op8(8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

        // start held and operands churning while the first request runs
        a0 = 8'h9C; b0 = 8'h47; bin0 = 1'b1; start0 = 1'b1;
        repeat (9) begin
            @(negedge clk);
            a0 = 8'($urandom); b0 = 8'($urandom); bin0 = 1'($urandom);
        end
        start0 = 1'b0;
        repeat (4) @(negedge clk);

        // reset sampled during the 4th RUN cycle
        a0 = 8'hC3; b0 = 8'h5A; bin0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (12) @(negedge clk);
        op8(8'h71, 8'hA4, 1'b1);

        for (int i = 0; i < 8; i++) op1(i[2], i[1], i[0]);
        start1 = 1'b1;
        repeat (30) begin
            a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
            @(negedge clk);
        end
        start1 = 1'b0;
        repeat (4) @(negedge clk);

        // back-to-back with start held high
        start0 = 1'b1;
        repeat (60) begin
            a0 = 8'($urandom); b0 = 8'($urandom); bin0 = 1'($urandom);
            @(negedge clk);
        end
        start0 = 1'b0;
        repeat (15) @(negedge clk);

        chk("pending_w8", 0, 64'(sbq[0].size()), 64'd0);
        chk("pending_w1", 1, 64'(sbq[1].size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
